// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU pipeline types: fetch FSM states and the IF/ID bundle.
// Imported by the fetch stage and, later, the decode stage.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM bus and IF/ID outputs of the fetch stage.
// The fetch unit is the master; ROM and decode sit on the slave side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] rom_address;
  logic [31:0]       rom_q;
  logic              ifid_valid;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic [ADDR_W-1:0] ifid_pc_next;

  modport master (
    output rom_address,
    input  rom_q,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_next
  );

  modport slave (
    input  rom_address,
    output rom_q,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_next
  );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with next-PC select: redirect, increment or hold.
// Arithmetic wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (advance) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: start/halt FSM, PC, and IF/ID register.
// The ROM answers combinationally, so the capture happens on the same edge.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  instr_fetch_unit_if.master bus,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              running
);

  fetch_state_t      state_d;
  fetch_state_t      state_q;
  ifid_t             ifid_d;
  ifid_t             ifid_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              pc_load;
  logic              pc_adv;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (pc_load),
    .target  (redirect_target),
    .advance (pc_adv),
    .pc      (pc)
  );

  assign pc_inc = pc + ADDR_W'(PC_STEP);

  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    pc_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        ifid_d.valid = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_load      = 1'b1;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
          if (halt_req) state_d = HALT;
        end else if (halt_req) begin
          state_d      = HALT;
          ifid_d.valid = 1'b0;
        end else if (!stall) begin
          ifid_d.valid   = 1'b1;
          ifid_d.instr   = bus.rom_q;
          ifid_d.pc      = PC_W'(pc);
          ifid_d.pc_next = PC_W'(pc_inc);
          pc_adv         = 1'b1;
          // saturate instead of wrapping
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      HALT: begin
        ifid_d.valid = 1'b0;
        pc_load      = redirect_valid;
        if (start && !halt_req) state_d = RUN;
      end
      default: begin
        state_d      = IDLE;
        ifid_d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ifid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rom_address  = pc;
  assign bus.ifid_valid   = ifid_q.valid;
  assign bus.ifid_instr   = ifid_q.instr;
  assign bus.ifid_pc      = ifid_q.pc[ADDR_W-1:0];
  assign bus.ifid_pc_next = ifid_q.pc_next[ADDR_W-1:0];
  assign fetch_count      = cnt_q;
  assign running          = (state_q == RUN);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: two fetch units (default and wrap/saturate params)
// driven by directed then random control, checked against a model.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, start, halt_req, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic        run0, run1;
  logic [31:0] rom [16];

  always #5 clock = ~clock;

  instr_fetch_unit_if #(.ADDR_W(32)) bus0 ();
  instr_fetch_unit_if #(.ADDR_W(32)) bus1 ();

  assign bus0.rom_q = rom[bus0.rom_address[3:0]];
  assign bus1.rom_q = rom[bus1.rom_address[3:0]];

  instr_fetch_unit dut0 (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .bus(bus0.master),
    .fetch_count(cnt0), .running(run0)
  );

  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFF), .CNT_W(4)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .bus(bus1.master),
    .fetch_count(cnt1), .running(run1)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] ipcn;
    logic [15:0] cnt;
    logic        run;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
  } pair_t;

  pair_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int          m_st   [2];
  logic [31:0] m_pc   [2];
  logic        m_v    [2];
  logic [31:0] m_ins  [2];
  logic [31:0] m_ipc  [2];
  logic [31:0] m_ipcn [2];
  int          m_cnt  [2];
  logic [31:0] rpc    [2];
  int          cmax   [2];

  task automatic model_step(input int d);
    if (reset) begin
      m_st[d] = 0; m_pc[d] = rpc[d]; m_v[d] = 1'b0; m_ins[d] = '0;
      m_ipc[d] = '0; m_ipcn[d] = '0; m_cnt[d] = 0;
    end else if (m_st[d] == 0) begin
      m_v[d] = 1'b0;
      if (start) m_st[d] = 1;
    end else if (m_st[d] == 1) begin
      if (redirect_valid) begin
        m_pc[d] = redirect_target; m_v[d] = 1'b0; m_ins[d] = '0;
        if (halt_req) m_st[d] = 2;
      end else if (halt_req) begin
        m_st[d] = 2; m_v[d] = 1'b0;
      end else if (!stall) begin
        m_ins[d]  = rom[m_pc[d][3:0]];
        m_ipc[d]  = m_pc[d];
        m_ipcn[d] = m_pc[d] + 32'd1;
        m_v[d]    = 1'b1;
        m_pc[d]   = m_pc[d] + 32'd1;
        if (m_cnt[d] < cmax[d]) m_cnt[d]++;
      end
    end else begin
      m_v[d] = 1'b0;
      if (redirect_valid) m_pc[d] = redirect_target;
      if (start && !halt_req) m_st[d] = 1;
    end
  endtask

  function automatic exp_t snap(input int d);
    exp_t e;
    e.pc = m_pc[d]; e.v = m_v[d]; e.ins = m_ins[d];
    e.ipc = m_ipc[d]; e.ipcn = m_ipcn[d];
    e.cnt = 16'(m_cnt[d]); e.run = (m_st[d] == 1);
    return e;
  endfunction

  task automatic step(input logic r, input logic s, input logic h,
                      input logic st, input logic rv,
                      input logic [31:0] rt);
    pair_t p;
    reset = r; start = s; halt_req = h; stall = st;
    redirect_valid = rv; redirect_target = rt;
    model_step(0);
    model_step(1);
    p.e0 = snap(0);
    p.e1 = snap(1);
    @(posedge clock);
    #1;
    sb.push_back(p);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      pair_t p;
      p = sb.pop_front();
      chk("d0.rom_address",  bus0.rom_address,  p.e0.pc);
      chk("d0.ifid_valid",   32'(bus0.ifid_valid), 32'(p.e0.v));
      chk("d0.ifid_instr",   bus0.ifid_instr,   p.e0.ins);
      chk("d0.ifid_pc",      bus0.ifid_pc,      p.e0.ipc);
      chk("d0.ifid_pc_next", bus0.ifid_pc_next, p.e0.ipcn);
      chk("d0.fetch_count",  32'(cnt0),         32'(p.e0.cnt));
      chk("d0.running",      32'(run0),         32'(p.e0.run));
      chk("d1.rom_address",  bus1.rom_address,  p.e1.pc);
      chk("d1.ifid_valid",   32'(bus1.ifid_valid), 32'(p.e1.v));
      chk("d1.ifid_instr",   bus1.ifid_instr,   p.e1.ins);
      chk("d1.ifid_pc",      bus1.ifid_pc,      p.e1.ipc);
      chk("d1.ifid_pc_next", bus1.ifid_pc_next, p.e1.ipcn);
      chk("d1.fetch_count",  32'(cnt1),         32'(p.e1.cnt));
      chk("d1.running",      32'(run1),         32'(p.e1.run));
    end
  end

  initial begin
    rpc[0] = 32'h0;  rpc[1] = 32'hFFFF_FFFF;
    cmax[0] = 65535; cmax[1] = 15;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    rom[0] = 32'h8C01_0000; rom[1] = 32'h8C02_0001;
    rom[2] = 32'h8C04_0002; rom[3] = 32'h0022_1820;
    rom[4] = 32'hAC03_0003;
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    @(posedge clock);
    #1;

    // program run, stall at ifid_pc=2, redirect under stall
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    // halt at pc=2, idle in HALT, resume
    step(0, 0, 1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    // halt-in-HALT priorities and redirect while halted
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    step(0, 1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // reset mid-run, then long run to saturate the narrow counter
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15))
                                      : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, t);
    end

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
